// File: rtl/hpm_pkt_pkg.sv
// Shared constants, state encoding and header helper for the HPM snapshot
// packetizer. Build option: HPM_HI_WORDS_EN (send both halves of each counter).
package hpm_pkt_pkg;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [31:0] ARM_VAL           = 32'h0000_0000;
    localparam logic [31:0] DISARM_VAL        = 32'hFFFF_FFFF;
    localparam logic [7:0]  HDR_MAGIC         = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SEND  = 2'd2
    } hpm_state_e;

    // Packet header: magic byte, payload length in words, sequence number.
    function automatic logic [31:0] hdr_build(input logic [7:0] len, input logic [15:0] seq);
        return {HDR_MAGIC, len, seq};
    endfunction

    // Saturating 16-bit increment used by the drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

endpackage

// File: rtl/hpm_period_timer.sv
// Free-running sample-period counter. Clear forces the count to zero and
// suppresses the trigger; the trigger pulses on the wrap cycle while enabled.
module hpm_period_timer #(
    parameter int unsigned PERIOD = 1024
) (
    input  logic clk_h,
    input  logic rst_h,
    input  logic clr_i,
    input  logic en_i,
    output logic trig_o
);

    localparam int unsigned CW = $clog2(PERIOD);
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap_s;

    // Next count: clear wins, otherwise count up and wrap at PERIOD-1.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_s = (cnt_q == LAST);
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = wrap_s ? '0 : (cnt_q + CW'(1));
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign trig_o = en_i && !clr_i && wrap_s;

endmodule

// File: rtl/hpm_snapshot_packetizer.sv
// HPM snapshot packetizer: armed/disarmed through mcountinhibit writes, it
// samples the counter bank every SAMPLE_PERIOD cycles and streams each
// snapshot as a header plus payload words on a valid/ready interface.
// Build option: HPM_HI_WORDS_EN sends each counter as low word then high word.
module hpm_snapshot_packetizer
    import hpm_pkt_pkg::*;
#(
    parameter int unsigned NUM_CNT       = 12,
    parameter int unsigned SAMPLE_PERIOD = 1024,
    parameter int unsigned SEQ_W         = 16
) (
    input  logic               clk_h,
    input  logic               rst_h,
    input  logic               csr_we,
    input  logic [11:0]        csr_add,
    input  logic [31:0]        csr_data,
    input  logic [31:0][63:0]  HPM,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [31:0]        m_data,
    output logic               m_last,
    output logic               active_o,
    output logic [15:0]        drop_cnt_o
);

`ifdef HPM_HI_WORDS_EN
    localparam int unsigned LEN = 2 * NUM_CNT;
`else
    localparam int unsigned LEN = NUM_CNT;
`endif
    localparam int unsigned IDX_W = $clog2(LEN + 1);
    localparam logic [7:0]  LEN8  = 8'(LEN);

    hpm_state_e                  state_q, state_d;
    logic [SEQ_W-1:0]            seq_q, seq_d;
    logic [15:0]                 drop_q, drop_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic                        pend_q, pend_d;
    logic                        valid_q, valid_d;
    logic [31:0]                 data_q, data_d;
    logic                        last_q, last_d;
    logic [NUM_CNT-1:0][31:0]    snap_lo_q, snap_lo_d;
`ifdef HPM_HI_WORDS_EN
    logic [NUM_CNT-1:0][31:0]    snap_hi_q, snap_hi_d;
`endif

    logic        arm_s;
    logic        dis_s;
    logic        hs_s;
    logic        trig_s;
    logic        cap_s;
    logic        tmr_clr_s;
    logic        tmr_en_s;
    logic [31:0] nxt_word_s;
    logic        unused_hpm_s;

    // Counter bits outside the captured range are intentionally ignored.
    assign unused_hpm_s = ^HPM;

    assign arm_s    = csr_we && (csr_add == CSR_MCOUNTINHIBIT) && (csr_data == ARM_VAL);
    assign dis_s    = csr_we && (csr_add == CSR_MCOUNTINHIBIT) && (csr_data == DISARM_VAL);
    assign hs_s     = valid_q && m_ready;
    assign tmr_en_s = (state_q != IDLE);

    hpm_period_timer #(
        .PERIOD (SAMPLE_PERIOD)
    ) u_timer (
        .clk_h  (clk_h),
        .rst_h  (rst_h),
        .clr_i  (tmr_clr_s),
        .en_i   (tmr_en_s),
        .trig_o (trig_s)
    );

    // Payload word following the one currently presented (idx_q is the
    // index of the word on m_data, so the next payload slot is idx_q).
    always_comb begin
        nxt_word_s = 32'h0000_0000;
        for (int k = 0; k < int'(NUM_CNT); k++) begin
`ifdef HPM_HI_WORDS_EN
            if (idx_q == IDX_W'(2 * k)) begin
                nxt_word_s = snap_lo_q[k];
            end else if (idx_q == IDX_W'(2 * k + 1)) begin
                nxt_word_s = snap_hi_q[k];
            end else begin
                nxt_word_s = nxt_word_s;
            end
`else
            if (idx_q == IDX_W'(k)) begin
                nxt_word_s = snap_lo_q[k];
            end else begin
                nxt_word_s = nxt_word_s;
            end
`endif
        end
    end

    // Snapshot capture: load the whole bank on an accepted trigger.
    always_comb begin
        snap_lo_d = snap_lo_q;
`ifdef HPM_HI_WORDS_EN
        snap_hi_d = snap_hi_q;
`endif
        if (cap_s) begin
            for (int k = 0; k < int'(NUM_CNT); k++) begin
                snap_lo_d[k] = HPM[k][31:0];
`ifdef HPM_HI_WORDS_EN
                snap_hi_d[k] = HPM[k][63:32];
`endif
            end
        end else begin
            snap_lo_d = snap_lo_q;
        end
    end

    // Control FSM and stream output next-state.
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        drop_d    = drop_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        valid_d   = valid_q;
        data_d    = data_q;
        last_d    = last_q;
        cap_s     = 1'b0;
        tmr_clr_s = 1'b0;
        case (state_q)
            IDLE: begin
                tmr_clr_s = 1'b1;
                if (arm_s) begin
                    state_d = ARMED;
                    seq_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ARMED: begin
                if (dis_s) begin
                    // Disarm takes priority over a coincident trigger.
                    state_d = IDLE;
                end else if (arm_s) begin
                    tmr_clr_s = 1'b1;
                end else if (trig_s) begin
                    cap_s   = 1'b1;
                    state_d = SEND;
                    valid_d = 1'b1;
                    data_d  = hdr_build(LEN8, 16'(seq_q));
                    last_d  = 1'b0;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ARMED;
                end
            end
            SEND: begin
                // Any trigger while a packet is outstanding is lost.
                if (trig_s) begin
                    drop_d = sat_inc16(drop_q);
                end else begin
                    drop_d = drop_q;
                end
                if (dis_s) begin
                    pend_d = 1'b1;
                end else if (arm_s) begin
                    pend_d = 1'b0;
                end else begin
                    pend_d = pend_q;
                end
                if (hs_s) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = 32'h0000_0000;
                        seq_d   = seq_q + SEQ_W'(1);
                        state_d = pend_d ? IDLE : ARMED;
                        pend_d  = 1'b0;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        data_d = nxt_word_s;
                        last_d = (idx_q == IDX_W'(LEN - 1));
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
                data_d  = 32'h0000_0000;
            end
        endcase
    end

    // State, sequence, drop counter and registered stream outputs.
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            state_q <= IDLE;
            seq_q   <= '0;
            drop_q  <= 16'h0000;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 32'h0000_0000;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            drop_q  <= drop_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Snapshot registers.
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            snap_lo_q <= '0;
`ifdef HPM_HI_WORDS_EN
            snap_hi_q <= '0;
`endif
        end else begin
            snap_lo_q <= snap_lo_d;
`ifdef HPM_HI_WORDS_EN
            snap_hi_q <= snap_hi_d;
`endif
        end
    end

    assign m_valid    = valid_q;
    assign m_data     = data_q;
    assign m_last     = last_q;
    assign drop_cnt_o = drop_q;
    assign active_o   = (state_q != IDLE);

endmodule

// File: tb/tb_hpm_snapshot_packetizer.sv
// Self-checking bench for hpm_snapshot_packetizer (NUM_CNT=12, SAMPLE_PERIOD=16).
// A reference model pushes expected packet words into a queue at each
// accepted trigger; words are popped and compared as the DUT presents them.
module tb_hpm_snapshot_packetizer;

    localparam int unsigned N = 12;
    localparam int unsigned P = 16;
`ifdef HPM_HI_WORDS_EN
    localparam int unsigned LEN = 2 * N;
`else
    localparam int unsigned LEN = N;
`endif

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        exp_active;
    } csr_vec_t;

    logic              clk_h;
    logic              rst_h;
    logic              csr_we;
    logic [11:0]       csr_add;
    logic [31:0]       csr_data;
    logic [31:0][63:0] hpm_s;
    logic              m_valid;
    logic              m_ready;
    logic [31:0]       m_data;
    logic              m_last;
    logic              active_o;
    logic [15:0]       drop_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t        exp_q[$];
    logic [31:0] obs_q[$];
    int          ms     = 0;
    int unsigned mph    = 0;
    logic [15:0] mseq   = 16'h0000;
    logic [15:0] exp_drop = 16'h0000;
    bit          mpend  = 1'b0;

    hpm_snapshot_packetizer #(
        .NUM_CNT       (N),
        .SAMPLE_PERIOD (P),
        .SEQ_W         (16)
    ) dut (
        .clk_h      (clk_h),
        .rst_h      (rst_h),
        .csr_we     (csr_we),
        .csr_add    (csr_add),
        .csr_data   (csr_data),
        .HPM        (hpm_s),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .active_o   (active_o),
        .drop_cnt_o (drop_cnt_o)
    );

    initial clk_h = 1'b0;
    always #5 clk_h = ~clk_h;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_packet();
        exp_t e;
        e.data = {8'hA5, 8'(LEN), mseq};
        e.last = 1'b0;
        exp_q.push_back(e);
        for (int w = 0; w < int'(LEN); w++) begin
`ifdef HPM_HI_WORDS_EN
            e.data = (w % 2 == 0) ? hpm_s[w / 2][31:0] : hpm_s[w / 2][63:32];
`else
            e.data = hpm_s[w][31:0];
`endif
            e.last = (w == int'(LEN) - 1);
            exp_q.push_back(e);
        end
    endtask

    // One clock: advance the model with pre-edge inputs, then check outputs.
    task automatic step();
        bit arm, dis, hs, lastw, trig;
        int unsigned ph_nx;
        exp_t e;
        arm   = csr_we && (csr_add == 12'h320) && (csr_data == 32'h0000_0000);
        dis   = csr_we && (csr_add == 12'h320) && (csr_data == 32'hFFFF_FFFF);
        hs    = m_valid && m_ready;
        lastw = 1'b0;
        if (hs) begin
            chk("handshake_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e     = exp_q.pop_front();
                lastw = e.last;
                obs_q.push_back(m_data);
            end
        end
        ph_nx = (mph == P - 1) ? 0 : mph + 1;
        trig  = (ms != 0) && (mph == P - 1) && !(arm && ms == 1);
        case (ms)
            0: begin
                mph = 0;
                if (arm) begin ms = 1; mseq = 16'h0000; end
            end
            1: begin
                if (dis) begin
                    ms = 0; mph = 0;
                end else if (arm) begin
                    mph = 0;
                end else begin
                    if (trig) begin push_packet(); ms = 2; mpend = 1'b0; end
                    mph = ph_nx;
                end
            end
            default: begin
                mph = ph_nx;
                if (trig && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
                if (dis) mpend = 1'b1;
                if (hs && lastw) begin
                    mseq  = mseq + 16'd1;
                    ms    = mpend ? 0 : 1;
                    if (ms == 0) mph = 0;
                    mpend = 1'b0;
                end
            end
        endcase
        @(posedge clk_h);
        #1;
        csr_we = 1'b0;
        chk("active_o", 64'(active_o), 64'(ms != 0));
        chk("drop_cnt_o", 64'(drop_cnt_o), 64'(exp_drop));
        chk("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
        if (m_valid && exp_q.size() != 0) begin
            chk("m_data", 64'(m_data), 64'(exp_q[0].data));
            chk("m_last", 64'(m_last), 64'(exp_q[0].last));
        end
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_add = a; csr_data = d;
        step();
    endtask

    task automatic wait_hdr(input string nm);
        int k = 0;
        while (!(m_valid && exp_q.size() == LEN + 1) && k < 200) begin
            step();
            k++;
        end
        chk(nm, 64'(k < 200), 64'd1);
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while (exp_q.size() != 0 && k < 400) begin
            step();
            k++;
        end
        chk(nm, 64'(k < 400), 64'd1);
    endtask

    initial begin
        csr_vec_t vt[8];
        int       saved;
        vt[0] = '{1'b1, 12'h321, 32'h0000_0000, 1'b0};
        vt[1] = '{1'b1, 12'h320, 32'h0000_0001, 1'b0};
        vt[2] = '{1'b0, 12'h320, 32'h0000_0000, 1'b0};
        vt[3] = '{1'b1, 12'h320, 32'h0000_0000, 1'b1};
        vt[4] = '{1'b1, 12'h320, 32'hFFFF_FFFE, 1'b1};
        vt[5] = '{1'b1, 12'h321, 32'hFFFF_FFFF, 1'b1};
        vt[6] = '{1'b0, 12'h320, 32'hFFFF_FFFF, 1'b1};
        vt[7] = '{1'b1, 12'h320, 32'hFFFF_FFFF, 1'b0};

        rst_h = 1'b0; csr_we = 1'b0; csr_add = 12'h000; csr_data = 32'h0; m_ready = 1'b0;
        for (int i = 0; i < 32; i++) hpm_s[i] = 64'(i * 100);
`ifdef HPM_HI_WORDS_EN
        hpm_s[3] = 64'h0000_0001_2345_6789;
`endif
        repeat (3) @(posedge clk_h);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_active", 64'(active_o), 64'd0);
        chk("rst_drop", 64'(drop_cnt_o), 64'd0);
        rst_h = 1'b1;
        step();

        // CSR decode table.
        for (int i = 0; i < 8; i++) begin
            csr_we = vt[i].we; csr_add = vt[i].addr; csr_data = vt[i].data;
            step();
            chk($sformatf("csr_vec%0d_active", i), 64'(active_o), 64'(vt[i].exp_active));
        end

        // Basic packets with m_ready held high.
        obs_q.delete();
        m_ready = 1'b1;
        csr_wr(12'h320, 32'h0000_0000);
        begin
            int k = 0;
            while (obs_q.size() < 2 * (LEN + 1) && k < 200) begin step(); k++; end
            chk("two_packets_timeout", 64'(k < 200), 64'd1);
        end
        if (obs_q.size() >= 2 * (LEN + 1)) begin
`ifdef HPM_HI_WORDS_EN
            chk("hdr0_const", 64'(obs_q[0]), 64'h0000_0000_A518_0000);
            chk("hi_word7", 64'(obs_q[7]), 64'h0000_0000_2345_6789);
            chk("hi_word8", 64'(obs_q[8]), 64'h0000_0000_0000_0001);
            chk("hdr1_const", 64'(obs_q[LEN + 1]), 64'h0000_0000_A518_0001);
`else
            chk("hdr0_const", 64'(obs_q[0]), 64'h0000_0000_A50C_0000);
            chk("word4_const", 64'(obs_q[4]), 64'd300);
            chk("word12_const", 64'(obs_q[12]), 64'd1100);
            chk("hdr1_const", 64'(obs_q[LEN + 1]), 64'h0000_0000_A50C_0001);
`endif
        end

        // m_ready toggling every cycle mid-packet.
        m_ready = 1'b0;
        wait_hdr("toggle_hdr_timeout");
        begin
            int k = 0;
            while (exp_q.size() != 0 && k < 200) begin
                m_ready = ~m_ready;
                step();
                k++;
            end
            chk("toggle_drain_timeout", 64'(k < 200), 64'd1);
        end

        // Long stall: triggers are dropped; the held packet keeps old values.
        m_ready = 1'b0;
        wait_hdr("stall_hdr_timeout");
        for (int i = 0; i < 32; i++) hpm_s[i] = hpm_s[i] + 64'd7;
        repeat (40) step();
        m_ready = 1'b1;
        drain("stall_drain_timeout");
        chk("stall_drops_nonzero", 64'(drop_cnt_o != 16'h0000), 64'd1);

        // DISARM while word 5 is presented: packet completes, then silence.
        wait_hdr("disarm_hdr_timeout");
        repeat (5) step();
        csr_wr(12'h320, 32'hFFFF_FFFF);
        drain("disarm_drain_timeout");
        saved = obs_q.size();
        repeat (50) step();
        chk("disarm_no_more_words", 64'(obs_q.size()), 64'(saved));
        chk("disarm_idle", 64'(active_o), 64'd0);

        // Reset in the middle of a packet.
        m_ready = 1'b0;
        csr_wr(12'h320, 32'h0000_0000);
        wait_hdr("rst_hdr_timeout");
        m_ready = 1'b1;
        repeat (3) step();
        rst_h = 1'b0;
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_m_last", 64'(m_last), 64'd0);
        chk("midrst_drop", 64'(drop_cnt_o), 64'd0);
        chk("midrst_active", 64'(active_o), 64'd0);
        exp_q.delete(); ms = 0; mph = 0; mseq = 16'h0000; exp_drop = 16'h0000; mpend = 1'b0;
        repeat (2) @(posedge clk_h);
        #1;
        rst_h = 1'b1;
        repeat (40) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hpm_snapshot_packetizer.md
Name: hpm_snapshot_packetizer

Overview:
- Synthesizable stage that consumes the core's CSR-write stream and the HPM counter bank.
- Feeds the HPM trace path in hardware instead of the simulation-only file log.
- Armed/disarmed by writes to mcountinhibit (0x320).
- While armed, snapshots counters every SAMPLE_PERIOD cycles and streams each snapshot as a framed packet of 32-bit words over a valid/ready interface to the downstream logger (UART/DMA/detector).

Parameters:
- NUM_CNT, 12: counters captured, HPM[0..NUM_CNT-1]; range 1..32.
- SAMPLE_PERIOD, 1024: cycles between snapshot triggers; must be >= 2.
- SEQ_W, 16: packet sequence-number width; must be <= 16.

Ports:
- clk_h  in  1  core clock
- rst_h  in  1  asynchronous active-low reset
- csr_we  in  1  CSR write strobe, one cycle per retired CSR write
- csr_add  in  12  CSR address of the write
- csr_data  in  32  CSR write data
- HPM  in  32x64  HPM counter bank
- m_valid  out  1  stream word valid
- m_ready  in  1  downstream ready
- m_data  out  32  stream word
- m_last  out  1  final word of packet
- active_o  out  1  high while armed or draining a packet
- drop_cnt_o  out  16  saturating count of dropped triggers

Behaviour:
- Reset (async, rst_h=0): state IDLE; m_valid=0, m_last=0, m_data=0, active_o=0, drop_cnt_o=0; seq=0; period counter=0; snapshot registers=0.
  - Reset mid-packet aborts the packet immediately; no completion.
- Control decode, only when csr_we=1 and csr_add=12'h320:
  - data 32'h0 = ARM.
  - data 32'hFFFFFFFF = DISARM.
  - Other data or addresses are ignored.
- States:
  - IDLE: period counter held 0. ARM -> ARMED, seq cleared.
  - ARMED: period counter increments each cycle and wraps at SAMPLE_PERIOD-1; the wrap cycle is a trigger.
    - Trigger -> latch HPM[i][31:0] for all i into snapshot, -> SEND.
    - DISARM -> IDLE.
    - ARM while ARMED restarts the period counter at 0.
  - SEND: words sent in order.
    - Word 0 = header {8'hA5, 8'(NUM_CNT), seq zero-extended to 16 bits}.
    - Words 1..NUM_CNT = snapshot[k-1].
    - The period counter keeps running. A trigger in SEND is dropped: drop_cnt_o increments, saturating at 16'hFFFF.
    - On handshake of the last word: seq increments (wraps mod 2^SEQ_W), -> ARMED, or -> IDLE if a DISARM arrived during SEND.
    - DISARM in SEND never truncates a packet.
- Precedence in the same cycle:
  - DISARM beats a trigger; no capture.
  - A trigger coinciding with the last-word handshake is dropped.
- Latency: trigger at clock edge T latches snapshot; m_valid=1 and header on m_data from T+1.
- Handshake:
  - A word transfers when m_valid && m_ready.
  - m_data and m_last are stable while m_valid && !m_ready.
  - m_valid never deasserts without a transfer, except on reset.
  - Back-to-back words with m_ready held high: one word per cycle, NUM_CNT+1 cycles per packet.
- active_o = (state != IDLE).

Optional Feature:
- HPM_HI_WORDS_EN defined:
  - Each counter is sent as two words, [31:0] then [63:32].
  - Snapshot holds the full 64 bits.
  - Header length field = 2*NUM_CNT.
  - Packet = 1+2*NUM_CNT words.
- Not defined: low 32 bits only, as above. Upper-half registers are not instantiated.

Decomposition:
- Package hpm_pkt_pkg holds:
  - CSR_MCOUNTINHIBIT=12'h320, ARM_VAL=32'h0, DISARM_VAL=32'hFFFFFFFF, HDR_MAGIC=8'hA5.
  - State enum {IDLE, ARMED, SEND}.
  - Header-build function.
- One sub-module, hpm_period_timer: period counter with clear/enable inputs and a trigger pulse output.

Test Plan (NUM_CNT=12, SAMPLE_PERIOD=16 unless noted):
- Reset then ARM, m_ready=1, HPM[i]=i*100 -> 16 cycles after ARM, header 32'hA50C0000 then words 0,100,...,1100; m_last on word 12; second packet header 32'hA50C0001.
- m_ready toggled 0/1 every cycle mid-packet -> m_data/m_last stable while stalled; all 13 words delivered in order, none duplicated.
- SAMPLE_PERIOD=4, m_ready=0 for 20 cycles after first trigger -> drop_cnt_o=4 (or 5 per exact phase, checked against model); packet content equals first snapshot.
- DISARM at word 5 of a packet -> packet completes with m_last; state IDLE; active_o=0; no further packets.
- Write 0 to csr_add=12'h321 and 32'h1 to 12'h320 -> no state change; rst_h pulsed low mid-packet -> m_valid=0 same cycle, drop_cnt_o=0.
- HPM_HI_WORDS_EN, HPM[3]=64'h0000_0001_2345_6789 -> header length 8'h18; words 7 and 8 = 32'h23456789 and 32'h00000001; packet 25 words.
